// File: rtl/sha3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha3_pkg
// Brief    : Shared types and helpers for the SHA-3 digest AXI-Stream
//            transmitter: digest mode, Keccak state and TX FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
package sha3_pkg;

    // Digest length selector, matches the 2-bit mode input / TUSER output
    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha3_mode_t;

    // Full Keccak-f[1600] state, indexed [x][y] -> 64-bit lane A[x][y]
    typedef logic [4:0][4:0][63:0] keccak_state_t;

    // Transmit FSM encoding
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Largest digest we ever stream: eight lanes
    localparam int C_DIGEST_MAX_BITS = 512;

    // Digest length in bytes for a given mode
    function automatic logic [6:0] digest_bytes(input sha3_mode_t m);
        logic [6:0] len;
        case (m)
            SHA3_224: len = 7'd28;
            SHA3_256: len = 7'd32;
            SHA3_384: len = 7'd48;
            default:  len = 7'd64;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha3_digest_axis_tx.sv
`default_nettype none
// ============================================================================
// Module   : sha3_digest_axis_tx
// Brief    : Captures the final Keccak state, truncates it to the selected
//            SHA-3 digest length and streams it as AXI-Stream beats with
//            TKEEP/TLAST and full TVALID/TREADY backpressure.
// Options  : SHA_TX_BSWAP_EN - reverse byte order inside every beat (and
//            the matching TKEEP bits); undefined gives little-endian packing.
// Revision : 1.0 - initial release
// ============================================================================
module sha3_digest_axis_tx
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [4:0][4:0][63:0]     state_in,
    input  logic                      state_valid,
    output logic                      state_ready,
    input  logic [1:0]                mode,
    input  logic [ID_WIDTH-1:0]       id,
    output logic [DATA_WIDTH-1:0]     M_TDATA,
    output logic [DATA_WIDTH/8-1:0]   M_TKEEP,
    output logic [ID_WIDTH-1:0]       M_TID,
    output logic [1:0]                M_TUSER,
    output logic                      M_TVALID,
    output logic                      M_TLAST,
    input  logic                      M_TREADY
);

    localparam int c_BYTES = DATA_WIDTH / 8;

    tx_state_t                       state_q, state_d;
    logic [C_DIGEST_MAX_BITS-1:0]    shreg_q, shreg_d;
    logic [6:0]                      cnt_q, cnt_d;
    logic [1:0]                      mode_q, mode_d;
    logic [ID_WIDTH-1:0]             id_q, id_d;

    logic [C_DIGEST_MAX_BITS-1:0]    w_lanes;
    logic [C_DIGEST_MAX_BITS-1:0]    w_lanes_masked;
    logic [6:0]                      w_len;
    logic [6:0]                      w_beats_m1;
    int                              w_rem;
    logic [c_BYTES-1:0]              w_keep_last;
    logic [c_BYTES-1:0]              w_keep;
    logic [DATA_WIDTH-1:0]           w_beat;
    logic                            w_sending;
    logic                            w_last;
    logic                            w_unused_state;

    // Only lanes 0..7 reach the digest; the rest of the state is dropped
    assign w_unused_state = ^state_in;

    // Lane i = x + 5y, packed so that digest byte b sits at bits 8b+:8
    assign w_lanes = {state_in[2][1], state_in[1][1], state_in[0][1],
                      state_in[4][0], state_in[3][0], state_in[2][0],
                      state_in[1][0], state_in[0][0]};

    // Truncate the captured lanes to the digest length and size the burst
    always_comb begin
        w_len      = digest_bytes(sha3_mode_t'(mode));
        w_beats_m1 = 7'((int'(w_len) + c_BYTES - 1) / c_BYTES - 1);
        w_lanes_masked = '0;
        for (int b = 0; b < 64; b++) begin
            w_lanes_masked[8*b +: 8] = (b < int'(w_len)) ? w_lanes[8*b +: 8] : 8'h00;
        end
    end

    // Next-state logic: capture when idle, shift one beat per handshake
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (state_valid) begin
                    shreg_d = w_lanes_masked;
                    cnt_d   = w_beats_m1;
                    mode_d  = mode;
                    id_d    = id;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (M_TREADY) begin
                    shreg_d = shreg_q >> DATA_WIDTH;
                    if (cnt_q == 7'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, shift register, beat counter and sideband registers
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            id_q    <= id_d;
        end
    end

    // Byte qualifiers: full beats except a possibly partial final beat
    always_comb begin
        w_sending   = (state_q == SEND);
        w_last      = w_sending && (cnt_q == 7'd0);
        w_rem       = int'(digest_bytes(sha3_mode_t'(mode_q))) % c_BYTES;
        w_keep_last = '0;
        for (int j = 0; j < c_BYTES; j++) begin
            w_keep_last[j] = (w_rem == 0) || (j < w_rem);
        end
        if (!w_sending) begin
            w_keep = '0;
        end else if (w_last) begin
            w_keep = w_keep_last;
        end else begin
            w_keep = '1;
        end
        w_beat = shreg_q[DATA_WIDTH-1:0];
    end

    // AXI-Stream outputs; all derive from registers so they stay stable under backpressure
    always_comb begin
        state_ready = (state_q == IDLE);
        M_TVALID    = w_sending;
        M_TLAST     = w_last;
        M_TID       = id_q;
        M_TUSER     = mode_q;
`ifdef SHA_TX_BSWAP_EN
        M_TDATA = '0;
        M_TKEEP = '0;
        for (int j = 0; j < c_BYTES; j++) begin
            M_TDATA[8*(c_BYTES-1-j) +: 8] = w_beat[8*j +: 8];
            M_TKEEP[c_BYTES-1-j]          = w_keep[j];
        end
`else
        M_TDATA = w_beat;
        M_TKEEP = w_keep;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_sha3_digest_axis_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha3_digest_axis_tx
// Brief    : Self-checking bench; drives a 16-bit and a 64-bit instance in
//            parallel from shared stimulus, expected beats kept in queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha3_digest_axis_tx;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [1:0]  tid;
        logic [1:0]  user;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [4:0][4:0][63:0]  st_in;
    logic                   st_valid;
    logic [1:0]             mode;
    logic [1:0]             idv;
    logic                   tready;

    logic                   ready16, valid16, last16;
    logic [15:0]            data16;
    logic [1:0]             keep16, tid16, user16;
    logic                   ready64, valid64, last64;
    logic [63:0]            data64;
    logic [7:0]             keep64;
    logic [1:0]             tid64, user64;

    beat_t q16[$];
    beat_t q64[$];
    int    tests_run = 0;
    int    fails     = 0;
    int    beats16   = 0;
    int    beats64   = 0;

    always #5 clk = ~clk;

    sha3_digest_axis_tx #(.DATA_WIDTH(16), .ID_WIDTH(2)) u_dut16 (
        .ACLK(clk), .ARESETn(rst_n), .state_in(st_in), .state_valid(st_valid),
        .state_ready(ready16), .mode(mode), .id(idv), .M_TDATA(data16),
        .M_TKEEP(keep16), .M_TID(tid16), .M_TUSER(user16), .M_TVALID(valid16),
        .M_TLAST(last16), .M_TREADY(tready)
    );

    sha3_digest_axis_tx #(.DATA_WIDTH(64), .ID_WIDTH(2)) u_dut64 (
        .ACLK(clk), .ARESETn(rst_n), .state_in(st_in), .state_valid(st_valid),
        .state_ready(ready64), .mode(mode), .id(idv), .M_TDATA(data64),
        .M_TKEEP(keep64), .M_TID(tid64), .M_TUSER(user64), .M_TVALID(valid64),
        .M_TLAST(last64), .M_TREADY(tready)
    );

    // Scoreboard for the 16-bit instance: compare every handshake
    always @(negedge clk) begin
        if (rst_n && valid16 && tready) begin
            tests_run++;
            if (q16.size() == 0) begin
                fails++;
                $display("FAIL beat16_unexpected: got data %h, expected no beat", data16);
            end else begin
                beat_t e;
                e = q16.pop_front();
                if (data16 !== e.data[15:0] || keep16 !== e.keep[1:0] || last16 !== e.last ||
                    tid16 !== e.tid || user16 !== e.user) begin
                    fails++;
                    $display("FAIL beat16_%0d: got data %h keep %b last %b id %0d user %0d, expected data %h keep %b last %b id %0d user %0d",
                             beats16, data16, keep16, last16, tid16, user16,
                             e.data[15:0], e.keep[1:0], e.last, e.tid, e.user);
                end
            end
            beats16++;
        end
    end

    // Scoreboard for the 64-bit instance
    always @(negedge clk) begin
        if (rst_n && valid64 && tready) begin
            tests_run++;
            if (q64.size() == 0) begin
                fails++;
                $display("FAIL beat64_unexpected: got data %h, expected no beat", data64);
            end else begin
                beat_t e;
                e = q64.pop_front();
                if (data64 !== e.data || keep64 !== e.keep || last64 !== e.last ||
                    tid64 !== e.tid || user64 !== e.user) begin
                    fails++;
                    $display("FAIL beat64_%0d: got data %h keep %h last %b id %0d user %0d, expected data %h keep %h last %b id %0d user %0d",
                             beats64, data64, keep64, last64, tid64, user64,
                             e.data, e.keep, e.last, e.tid, e.user);
                end
            end
            beats64++;
        end
    end

    // Reference model: digest bytes from lanes, packed into beats per width
    task automatic push_expected(input logic [4:0][4:0][63:0] st, input logic [1:0] m,
                                 input logic [1:0] tid);
        logic [7:0] db [64];
        int len, nb, idx, pos, w;
        beat_t e;
        for (int b = 0; b < 64; b++) begin
            db[b] = st[(b/8) % 5][(b/8) / 5][8*(b%8) +: 8];
        end
        len = (m == 2'd0) ? 28 : (m == 2'd1) ? 32 : (m == 2'd2) ? 48 : 64;
        for (int sel = 0; sel < 2; sel++) begin
            w  = (sel == 0) ? 2 : 8;
            nb = (len + w - 1) / w;
            for (int k = 0; k < nb; k++) begin
                e.data = '0;
                e.keep = '0;
                for (int j = 0; j < w; j++) begin
                    idx = k*w + j;
`ifdef SHA_TX_BSWAP_EN
                    pos = w - 1 - j;
`else
                    pos = j;
`endif
                    if (idx < len) begin
                        e.data[8*pos +: 8] = db[idx];
                        e.keep[pos]        = 1'b1;
                    end
                end
                e.last = (k == nb - 1);
                e.tid  = tid;
                e.user = m;
                if (sel == 0) q16.push_back(e);
                else          q64.push_back(e);
            end
        end
    endtask

    task automatic random_state(output logic [4:0][4:0][63:0] st);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                st[x][y] = {$urandom, $urandom};
    endtask

    // Wait for both instances idle, then present one state for one cycle
    task automatic send_state(input logic [4:0][4:0][63:0] st, input logic [1:0] m,
                              input logic [1:0] tid);
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (ready16 && ready64) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            tests_run++;
            fails++;
            $display("FAIL send_wait_ready: got ready16 %b ready64 %b, expected 1 1", ready16, ready64);
        end
        push_expected(st, m, tid);
        st_in    = st;
        mode     = m;
        idv      = tid;
        st_valid = 1'b1;
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (q16.size() == 0 && q64.size() == 0 && ready16 && ready64) begin
                done = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!done) begin
            fails++;
            $display("FAIL %s_drain: got %0d/%0d beats pending, expected 0/0", name, q16.size(), q64.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st_valid = 1'b0; tready = 1'b0; mode = 2'd0; idv = 2'd0; st_in = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({ready16, valid16, last16, data16, keep16, tid16, user16} !== {3'b100, 16'h0, 2'b0, 2'b0, 2'b0}) begin
            fails++;
            $display("FAIL reset16: got ready %b valid %b last %b data %h keep %b id %0d user %0d, expected 1 0 0 0000 00 0 0",
                     ready16, valid16, last16, data16, keep16, tid16, user16);
        end
        tests_run++;
        if ({ready64, valid64, last64, data64, keep64, tid64, user64} !== {3'b100, 64'h0, 8'h0, 2'b0, 2'b0}) begin
            fails++;
            $display("FAIL reset64: got ready %b valid %b last %b data %h keep %h, expected 1 0 0 0 00",
                     ready64, valid64, last64, data64, keep64);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic16();
        logic [4:0][4:0][63:0] st;
        logic [15:0] first_exp;
        random_state(st);
        st[0][0] = 64'h0123456789ABCDEF;
`ifdef SHA_TX_BSWAP_EN
        first_exp = 16'hEFCD;
`else
        first_exp = 16'hCDEF;
`endif
        beats16 = 0; beats64 = 0;
        tready  = 1'b1;
        send_state(st, 2'd1, 2'd2);
        tests_run++;
        if (data16 !== first_exp || valid16 !== 1'b1) begin
            fails++;
            $display("FAIL basic_first_beat: got valid %b data %h, expected 1 %h", valid16, data16, first_exp);
        end
        wait_drain("basic");
        tests_run++;
        if (beats16 != 16 || beats64 != 4) begin
            fails++;
            $display("FAIL basic_beat_count: got %0d/%0d, expected 16/4", beats16, beats64);
        end
    endtask

    task automatic test_mode0_64();
        logic [4:0][4:0][63:0] st;
        random_state(st);
        beats16 = 0; beats64 = 0;
        tready  = 1'b1;
        send_state(st, 2'd0, 2'd1);
        wait_drain("mode0");
        tests_run++;
        if (beats64 != 4 || beats16 != 14) begin
            fails++;
            $display("FAIL mode0_beat_count: got %0d/%0d, expected 4/14", beats64, beats16);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0][4:0][63:0] st;
        logic [15:0] hd;
        logic [1:0]  hk;
        logic        hl;
        bit          hit = 1'b0;
        random_state(st);
        beats16 = 0; beats64 = 0;
        tready  = 1'b1;
        send_state(st, 2'd3, 2'd3);
        for (int i = 0; i < 100; i++) begin
            if (beats16 == 5 && valid16) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        tready = 1'b0;
        hd = data16; hk = keep16; hl = last16;
        tests_run++;
        if (!hit) begin
            fails++;
            $display("FAIL bp_reach_beat5: got %0d beats, expected 5", beats16);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (data16 !== hd || keep16 !== hk || last16 !== hl || valid16 !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold_%0d: got valid %b data %h keep %b last %b, expected 1 %h %b %b",
                         c, valid16, data16, keep16, last16, hd, hk, hl);
            end
        end
        tready = 1'b1;
        wait_drain("bp");
        tests_run++;
        if (beats16 != 32 || beats64 != 8) begin
            fails++;
            $display("FAIL bp_beat_count: got %0d/%0d, expected 32/8", beats16, beats64);
        end
    endtask

    task automatic test_ignore();
        logic [4:0][4:0][63:0] st, st2;
        random_state(st);
        random_state(st2);
        beats16 = 0; beats64 = 0;
        tready  = 1'b1;
        send_state(st, 2'd3, 2'd0);
        @(posedge clk); #1;
        st_in = st2; mode = 2'd0; idv = 2'd3; st_valid = 1'b1;
        @(posedge clk); #1;
        st_valid = 1'b0;
        wait_drain("ignore");
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (beats16 != 32 || beats64 != 8 || valid16 !== 1'b0) begin
            fails++;
            $display("FAIL ignore_beat_count: got %0d/%0d valid %b, expected 32/8 0", beats16, beats64, valid16);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0][4:0][63:0] st;
        bit hit = 1'b0;
        random_state(st);
        beats16 = 0; beats64 = 0;
        tready  = 1'b1;
        send_state(st, 2'd3, 2'd2);
        for (int i = 0; i < 100; i++) begin
            if (beats16 == 7) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (!hit || valid16 !== 1'b0 || last16 !== 1'b0 || valid64 !== 1'b0) begin
            fails++;
            $display("FAIL midreset_valid: got valid16 %b last16 %b valid64 %b reached %b, expected 0 0 0 1",
                     valid16, last16, valid64, hit);
        end
        q16.delete();
        q64.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (ready16 !== 1'b1 || ready64 !== 1'b1 || data16 !== 16'h0) begin
            fails++;
            $display("FAIL midreset_ready: got ready %b/%b data %h, expected 1/1 0000", ready16, ready64, data16);
        end
        random_state(st);
        beats16 = 0; beats64 = 0;
        send_state(st, 2'd1, 2'd1);
        wait_drain("after_reset");
        tests_run++;
        if (beats16 != 16) begin
            fails++;
            $display("FAIL after_reset_count: got %0d, expected 16", beats16);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0][4:0][63:0] st;
        bit hit = 1'b0;
        random_state(st);
        tready = 1'b1;
        send_state(st, 2'd0, 2'd3);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid16 && last16 && tready) begin
                hit = 1'b1;
                break;
            end
        end
        @(negedge clk);
        tests_run++;
        if (!hit || ready16 !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready_gap: got ready %b reached %b, expected 1 1", ready16, hit);
        end
        @(posedge clk); #1;
        random_state(st);
        send_state(st, 2'd2, 2'd0);
        random_state(st);
        send_state(st, 2'd1, 2'd2);
        wait_drain("b2b");
    endtask

    initial begin
        test_reset();
        test_basic16();
        test_mode0_64();
        test_backpressure();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
